muldiv_hilo_ctrl: RTL and testbench

Execute-stage controller for the MIPS MULT/MULTU/DIV/DIVU instructions. It owns the HI/LO register pair and sequences an iterative shift-add multiplier and a restoring divider, one bit per cycle. While an operation is in flight it stalls any younger instruction that touches HI/LO or issues another mult/div. It sits beside the ALU and takes its operands from the same forwarded rs/rt values that feed SrcA/SrcB.

---
 rtl/muldiv_hilo_ctrl_if.sv | 29 ++
 rtl/muldiv_hilo_ctrl.sv | 157 +++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_ctrl_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply-divide controller.
interface muldiv_hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             rd_hilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div0;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wdata, rd_hilo,
        input  hi, lo, busy, stall, done, div0
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wdata, rd_hilo,
        output hi, lo, busy, stall, done, div0
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU: bit-serial shift-add multiplier and restoring
// divider on operand magnitudes, with sign fixup in a final cycle.
module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_hilo_ctrl_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, div0_q, div0_d;

    logic [1:0]         op_q, op_d;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, dvsr_q, dvsr_d, orig_a_q, orig_a_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quot_q, quot_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               a_neg, b_neg;
    logic [WIDTH:0]     msum, rsh;
    logic [2*WIDTH-1:0] mres;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] s;
        s = v;
        return (is_signed && s < 0) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div0_d    = 1'b0;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        mcand_d   = mcand_q;
        dvsr_d    = dvsr_q;
        orig_a_d  = orig_a_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        prod_d    = prod_q;
        a_neg     = bus.op[0] & bus.src_a[WIDTH-1];
        b_neg     = bus.op[0] & bus.src_b[WIDTH-1];
        msum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        rsh       = {rem_q, quot_q[WIDTH-1]};
        mres      = cneg_2w(prod_q, neg_res_q);

        case (state_q)
            S_IDLE: begin
                // MT writes land now even when a new operation is accepted alongside them
                if (bus.mthi) hi_d = bus.wdata;
                if (bus.mtlo) lo_d = bus.wdata;
                if (bus.start) begin
                    op_d      = bus.op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    zero_d    = bus.op[1] && (bus.src_b == '0);
                    mcand_d   = mag(bus.src_a, bus.op[0]);
                    dvsr_d    = mag(bus.src_b, bus.op[0]);
                    orig_a_d  = bus.src_a;
                    prod_d    = {{WIDTH{1'b0}}, mag(bus.src_b, bus.op[0])};
                    quot_d    = mag(bus.src_a, bus.op[0]);
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                    rem_d  = rsh[WIDTH-1:0];
                    if (rsh >= {1'b0, dvsr_q}) begin
                        rem_d     = rsh[WIDTH-1:0] - dvsr_q;
                        quot_d[0] = 1'b1;
                    end
                end else begin
                    prod_d = {msum, prod_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WIDTH - 1)) state_d = S_SIGN;
            end
            S_SIGN: begin
                if (!op_q[1]) begin
                    hi_d = mres[2*WIDTH-1:WIDTH];
                    lo_d = mres[WIDTH-1:0];
                end else if (zero_q) begin
                    hi_d = orig_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = cneg_w(rem_q, neg_rem_q);
                    lo_d = cneg_w(quot_q, neg_res_q);
                end
                done_d  = 1'b1;
                div0_d  = op_q[1] & zero_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    // Working registers are always reloaded on start, so they carry no reset
    always_ff @(posedge clk) begin
        op_q      <= op_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        zero_q    <= zero_d;
        mcand_q   <= mcand_d;
        dvsr_q    <= dvsr_d;
        orig_a_q  <= orig_a_d;
        rem_q     <= rem_d;
        quot_q    <= quot_d;
        prod_q    <= prod_d;
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.stall = bus.busy & (bus.start | bus.mthi | bus.mtlo | bus.rd_hilo);
    assign bus.done  = done_q;
    assign bus.div0  = div0_q;
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: queued expected HI/LO/div0 checked on every done pulse.
module tb_muldiv_hilo_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [64:0] exp_q[$];

    muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();
    muldiv_hilo_ctrl #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one queued expectation
    always @(negedge clk) begin
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no pulse");
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("res_hi", bus.hi, e[63:32]);
                chk("res_lo", bus.lo, e[31:0]);
                chk("res_div0", bus.div0, e[64]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [64:0] e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        if (push) exp_q.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [64:0] e);
        int n;
        issue(op, a, b, 1'b1, e);
        wait_done(n);
        chk({name, "_busy_cycles"}, n, 33);
        chk({name, "_done"}, bus.done, 1);
    endtask

    initial begin
        int  n;
        logic seen;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wdata   = '0;
        bus.rd_hilo = 1'b0;
        repeat (2) tick();
        bus.rd_hilo = 1'b1;
        #1;
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_div0", bus.div0, 0);
        chk("idle_stall", bus.stall, 0);
        bus.rd_hilo = 1'b0;
        reset = 1'b0;
        tick();

        run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        run("mult_neg",  2'b01, 32'hFFFF_FFF9, 32'd3,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run("divu_zero", 2'b10, 32'd100,       32'd0,         {1'b1, 32'd100,       32'hFFFF_FFFF});
        run("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000, 32'h8000_0000});

        // Hazards while a DIVU 50/7 is in flight
        issue(2'b10, 32'd50, 32'd7, 1'b1, {1'b0, 32'd1, 32'd7});
        repeat (3) tick();
        bus.rd_hilo = 1'b1;
        #1;
        chk("haz_rd_stall", bus.stall, 1);
        bus.rd_hilo = 1'b0;
        bus.mthi    = 1'b1;
        bus.wdata   = 32'hDEAD_BEEF;
        #1;
        chk("haz_mthi_stall", bus.stall, 1);
        tick();
        bus.mthi = 1'b0;
        chk("haz_hi_kept", bus.hi, 32'h0);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd9;
        bus.src_b = 32'd9;
        #1;
        chk("haz_start_stall", bus.stall, 1);
        tick();
        bus.start = 1'b0;
        chk("haz_lo_kept", bus.lo, 32'h8000_0000);
        wait_done(n);
        chk("haz_done", bus.done, 1);
        bus.mtlo    = 1'b1;
        bus.rd_hilo = 1'b1;
        bus.wdata   = 32'h0000_1234;
        #1;
        chk("done_cycle_stall", bus.stall, 0);
        tick();
        bus.mtlo    = 1'b0;
        bus.rd_hilo = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h0000_1234);
        chk("mtlo_hi", bus.hi, 32'd1);
        chk("stalled_start_dropped", bus.busy, 0);

        // Reset in the middle of a DIVU
        issue(2'b10, 32'd1000, 32'd3, 1'b0, '0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        run("multu_6x7", 2'b00, 32'd6, 32'd7, {1'b0, 32'd0, 32'd42});
        tick();

        // Start with MTHI in IDLE: MT write first, result overwrites later
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_AAAA;
        issue(2'b00, 32'd2, 32'd3, 1'b1, {1'b0, 32'd0, 32'd6});
        bus.mthi = 1'b0;
        chk("start_mthi_hi", bus.hi, 32'h0000_AAAA);
        wait_done(n);
        chk("start_mthi_busy_cycles", n, 33);
        chk("start_mthi_done", bus.done, 1);
        tick();
        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
